// File: rtl/lfsr_encrypter.sv
// Encrypting sequencer: emits a filler preamble followed by plaintext read from
// the data memory, each byte XORed with a 6-bit LFSR keystream, one write per clock.
module lfsr_encrypter #(
  parameter int             W        = 8,
  parameter int             ADDR_W   = 8,
  parameter int             PT_BASE  = 0,
  parameter int             CT_BASE  = 64,
  parameter int             CT_LEN   = 64,
  parameter logic [W-1:0]   PRE_CHAR = 8'h5F
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        pre_len,
  input  logic [3:0]        tap_sel,
  input  logic [5:0]        seed,
  input  logic [W-1:0]      mem_rdata,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic              mem_we,
  output logic [W-1:0]      mem_wdata,
  output logic              busy,
  output logic              done
);

  localparam int KW = $clog2(CT_LEN + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [KW-1:0] k_reg, k_next;
  logic [5:0]    lfsr_reg, lfsr_next;
  logic [5:0]    taps_reg, taps_next;
  logic [3:0]    plen_reg, plen_next;

  logic [5:0]    taps_lookup;
  logic [3:0]    plen_clamped;
  logic          in_preamble;
  logic [W-1:0]  p_byte;

  // Out-of-range selects fall back to the first pattern.
  always_comb begin
    case (tap_sel)
      4'd0:    taps_lookup = 6'h21;
      4'd1:    taps_lookup = 6'h2D;
      4'd2:    taps_lookup = 6'h30;
      4'd3:    taps_lookup = 6'h33;
      4'd4:    taps_lookup = 6'h36;
      4'd5:    taps_lookup = 6'h39;
      4'd6:    taps_lookup = 6'h3C;
      4'd7:    taps_lookup = 6'h3E;
      4'd8:    taps_lookup = 6'h3F;
      default: taps_lookup = 6'h21;
    endcase
  end

  always_comb begin
    if (pre_len < 4'd7)       plen_clamped = 4'd7;
    else if (pre_len > 4'd12) plen_clamped = 4'd12;
    else                      plen_clamped = pre_len;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      lfsr_reg  <= '0;
      taps_reg  <= '0;
      plen_reg  <= '0;
    end else begin
      state_reg <= state_next;
      k_reg     <= k_next;
      lfsr_reg  <= lfsr_next;
      taps_reg  <= taps_next;
      plen_reg  <= plen_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    lfsr_next  = lfsr_reg;
    taps_next  = taps_reg;
    plen_next  = plen_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = RUN;
          k_next     = '0;
          taps_next  = taps_lookup;
          plen_next  = plen_clamped;
          // An all-zero seed would lock the LFSR at zero.
          lfsr_next  = (seed == 6'd0) ? 6'h01 : seed;
        end
      end
      RUN: begin
        k_next    = k_reg + 1'b1;
        lfsr_next = {lfsr_reg[4:0], ^(lfsr_reg & taps_reg)};
        if (k_reg == KW'(CT_LEN - 1)) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decode straight from state, so an asynchronous reset kills mem_we at once.
  assign in_preamble = (k_reg < KW'(plen_reg));
  assign p_byte      = in_preamble ? PRE_CHAR : mem_rdata;

  always_comb begin
    mem_raddr = '0;
    mem_waddr = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    busy      = (state_reg == RUN);
    done      = (state_reg == DONE);
    if (state_reg == RUN) begin
      mem_we    = 1'b1;
      mem_waddr = ADDR_W'(CT_BASE) + ADDR_W'(k_reg);
      mem_wdata = p_byte ^ W'(lfsr_reg);
      if (!in_preamble)
        mem_raddr = ADDR_W'(PT_BASE) + ADDR_W'(k_reg) - ADDR_W'(plen_reg);
    end
  end

endmodule
